// File: rtl/wb_arbiter.sv
// Write-back arbiter: five per-source FIFOs feeding the two register-file write ports,
// round-robin selected, with same-register suppression on port 1.
module wb_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [4:0]          src_valid,
    output logic [4:0]          src_ready,
    input  logic [5*ADDR_W-1:0] src_addr,
    input  logic [5*DATA_W-1:0] src_data,
    output logic                wr0_start,
    output logic [ADDR_W-1:0]   wr0_search,
    output logic [DATA_W-1:0]   wr0_data,
    output logic                wr1_start,
    output logic [ADDR_W-1:0]   wr1_search,
    output logic [DATA_W-1:0]   wr1_data,
    output logic                idle
);
    localparam int N     = 5;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [ADDR_W-1:0] mem_addr [N][DEPTH];
    logic [DATA_W-1:0] mem_data [N][DEPTH];
    logic [PTR_W-1:0]  rd_ptr   [N];
    logic [PTR_W-1:0]  wr_ptr   [N];
    logic [CNT_W-1:0]  count    [N];
    logic [2:0]        rr_ptr;

    logic [ADDR_W-1:0] head_addr [N];
    logic [DATA_W-1:0] head_data [N];
    logic [4:0]        push;
    logic [4:0]        pop;
    logic              g0_valid;
    logic              g1_valid;
    logic [2:0]        g0_src;
    logic [2:0]        g1_src;

    function automatic logic [2:0] wrap5(input logic [3:0] v);
        return (v >= 4'd5) ? 3'(v - 4'd5) : v[2:0];
    endfunction

    always_comb begin
        for (int i = 0; i < N; i++) begin
            head_addr[i] = mem_addr[i][rd_ptr[i]];
            head_data[i] = mem_data[i][rd_ptr[i]];
        end
    end

    // Port 0 scans from rr_ptr; port 1 continues after port 0 and is dropped
    // (not re-searched) when it would write the same register as port 0.
    always_comb begin
        logic [2:0] idx;
        idx      = '0;
        g0_valid = 1'b0;
        g0_src   = '0;
        g1_valid = 1'b0;
        g1_src   = '0;
        for (int k = 0; k < N; k++) begin
            idx = wrap5({1'b0, rr_ptr} + 4'(k));
            if (!g0_valid && count[idx] != '0) begin
                g0_valid = 1'b1;
                g0_src   = idx;
            end
        end
        for (int k = 1; k < N; k++) begin
            idx = wrap5({1'b0, g0_src} + 4'(k));
            if (g0_valid && !g1_valid && count[idx] != '0) begin
                g1_valid = 1'b1;
                g1_src   = idx;
            end
        end
        if (g1_valid && head_addr[g1_src] == head_addr[g0_src]) begin
            g1_valid = 1'b0;
        end
    end

    // Handshake: a beat transfers at a rising edge when src_valid[i] & src_ready[i];
    // ready depends only on the registered count, so a full FIFO refuses even while popped.
    always_comb begin
        idle = 1'b1;
        for (int i = 0; i < N; i++) begin
            src_ready[i] = rst_n && (count[i] < CNT_W'(DEPTH));
            pop[i]       = (g0_valid && g0_src == 3'(i)) || (g1_valid && g1_src == 3'(i));
            if (count[i] != '0) idle = 1'b0;
        end
        push = src_valid & src_ready;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                count[i]  <= '0;
                rd_ptr[i] <= '0;
                wr_ptr[i] <= '0;
            end
            rr_ptr <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (push[i]) wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
                if (pop[i])  rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
                count[i] <= count[i] + CNT_W'(push[i]) - CNT_W'(pop[i]);
            end
            if (g1_valid) begin
                rr_ptr <= wrap5({1'b0, g1_src} + 4'd1);
            end else if (g0_valid) begin
                rr_ptr <= wrap5({1'b0, g0_src} + 4'd1);
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (push[i]) begin
                mem_addr[i][wr_ptr[i]] <= src_addr[i*ADDR_W +: ADDR_W];
                mem_data[i][wr_ptr[i]] <= src_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign wr0_start  = g0_valid;
    assign wr0_search = g0_valid ? head_addr[g0_src] : '0;
    assign wr0_data   = g0_valid ? head_data[g0_src] : '0;
    assign wr1_start  = g1_valid;
    assign wr1_search = g1_valid ? head_addr[g1_src] : '0;
    assign wr1_data   = g1_valid ? head_data[g1_src] : '0;

endmodule
